// File: rtl/hdmi_video_timing_pattern_gen_if.sv
// Video bundle between the timing/pattern generator and the TMDS encoder stage.
// The master side is the generator: it takes pattern controls and drives pixels and syncs.
interface hdmi_video_timing_pattern_gen_if;
   logic [1:0]  pattern_sel;
   logic [23:0] solid_rgb;
   logic [7:0]  rgb_r;
   logic [7:0]  rgb_g;
   logic [7:0]  rgb_b;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic        frame_start;

   modport master (
      input  pattern_sel, solid_rgb,
      output rgb_r, rgb_g, rgb_b, de, hsync, vsync, frame_start
   );

   modport slave (
      output pattern_sel, solid_rgb,
      input  rgb_r, rgb_g, rgb_b, de, hsync, vsync, frame_start
   );
endinterface

// File: rtl/hdmi_video_timing_pattern_gen.sv
// Raster timing (DE/HSYNC/VSYNC) and test-pattern RGB source for the HDMI TMDS encoders.
// Every output is registered from the counter state of the previous cycle.
module hdmi_video_timing_pattern_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int CW       = 12
) (
   input  logic                                  video_clk_pix,
   input  logic                                  video_rst_n,
   hdmi_video_timing_pattern_gen_if.master       vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   logic [CW-1:0] h_cnt_q, h_cnt_d;
   logic [CW-1:0] v_cnt_q, v_cnt_d;
   logic [CW-1:0] ib_cnt_q, ib_cnt_d;
   logic [2:0]    bar_q, bar_d;
   logic [1:0]    pat_q, pat_d;
   logic          h_wrap;
   logic          first_px;
   logic          de_d, hs_d, vs_d;
   logic [23:0]   rgb_d;

   logic [7:0]    rgb_r_q, rgb_g_q, rgb_b_q;
   logic          de_q, hs_q, vs_q, fs_q;

   always_comb begin
      h_wrap   = (h_cnt_q == H_LAST);
      first_px = (h_cnt_q == '0) && (v_cnt_q == '0);

      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;

      // Bar state tracks h_cnt_q so the bar index is known without dividing h_cnt.
      ib_cnt_d = ib_cnt_q + 1'b1;
      bar_d    = bar_q;
      if (h_wrap) begin
         ib_cnt_d = '0;
         bar_d    = '0;
      end else if (ib_cnt_q == BAR_LAST) begin
         ib_cnt_d = '0;
         bar_d    = bar_q + 3'd1;
      end

      // The frame's first pixel already uses the newly captured selection.
      pat_d = first_px ? vid.pattern_sel : pat_q;

      de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? H_POL : ~H_POL;
      vs_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? V_POL : ~V_POL;

      case (pat_d)
         2'd0:    rgb_d = bar_colour(bar_q);
         2'd1:    rgb_d = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'hFFFFFF : 24'h000000;
         2'd2:    rgb_d = {3{h_cnt_q[7:0]}};
         default: rgb_d = vid.solid_rgb;
      endcase
      if (!de_d) rgb_d = '0;
   end

   always_ff @(posedge video_clk_pix) begin
      if (!video_rst_n) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         ib_cnt_q <= '0;
         bar_q    <= '0;
         pat_q    <= '0;
         rgb_r_q  <= '0;
         rgb_g_q  <= '0;
         rgb_b_q  <= '0;
         de_q     <= 1'b0;
         hs_q     <= ~H_POL;
         vs_q     <= ~V_POL;
         fs_q     <= 1'b0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         ib_cnt_q <= ib_cnt_d;
         bar_q    <= bar_d;
         pat_q    <= pat_d;
         rgb_r_q  <= rgb_d[23:16];
         rgb_g_q  <= rgb_d[15:8];
         rgb_b_q  <= rgb_d[7:0];
         de_q     <= de_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         fs_q     <= first_px;
      end
   end

   assign vid.rgb_r       = rgb_r_q;
   assign vid.rgb_g       = rgb_g_q;
   assign vid.rgb_b       = rgb_b_q;
   assign vid.de          = de_q;
   assign vid.hsync       = hs_q;
   assign vid.vsync       = vs_q;
   assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_video_timing_pattern_gen.sv
// Directed bench for the HDMI timing/pattern generator on a tiny 24x8 raster.
module tb_hdmi_video_timing_pattern_gen;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hdmi_video_timing_pattern_gen_if vid();

   hdmi_video_timing_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b1),  .V_POL(1'b0), .CW(12)
   ) u_dut (
      .video_clk_pix (clk),
      .video_rst_n   (rst_n),
      .vid           (vid)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int k      = 0;

   logic        de_a  [192];
   logic        hs_a  [192];
   logic        vs_a  [192];
   logic        fs_a  [192];
   logic [23:0] rgb_a [192];
   logic [23:0] bars  [8];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (out idx %0d)", tag, act, exp, k);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic goto(input int target);
      while (k < target) tick();
   endtask

   function automatic logic [23:0] rgb_now();
      return {vid.rgb_r, vid.rgb_g, vid.rgb_b};
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_de"},    vid.de,          1'b0);
      check_val({tag, "_hs"},    vid.hsync,       1'b0);
      check_val({tag, "_vs"},    vid.vsync,       1'b1);
      check_val({tag, "_fs"},    vid.frame_start, 1'b0);
      check_val({tag, "_rgb"},   rgb_now(),       24'h000000);
   endtask

   initial begin
      int first_de_fall, first_hs, first_vs, de_line0, de_tot, hs_line0, hs_tot;
      int hs_in_vs, vs_low, fs_cnt, act_lines;
      logic [23:0] blank_or;
      logic        line_has_de;
      logic [7:0]  g;

      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

      vid.pattern_sel = 2'd0;
      vid.solid_rgb   = 24'h123456;
      rst_n           = 1'b0;
      repeat (5) tick();
      check_reset_outputs("rst_hold");

      rst_n = 1'b1;
      k = -1;
      for (int i = 0; i < 192; i++) begin
         tick();
         de_a[i]  = vid.de;
         hs_a[i]  = vid.hsync;
         vs_a[i]  = vid.vsync;
         fs_a[i]  = vid.frame_start;
         rgb_a[i] = rgb_now();
      end

      first_de_fall = -1; first_hs = -1; first_vs = -1;
      de_line0 = 0; de_tot = 0; hs_line0 = 0; hs_tot = 0;
      hs_in_vs = 0; vs_low = 0; fs_cnt = 0; act_lines = 0; blank_or = '0;
      for (int i = 0; i < 192; i++) begin
         if (!de_a[i] && first_de_fall < 0) first_de_fall = i;
         if (hs_a[i] && first_hs < 0) first_hs = i;
         if (!vs_a[i] && first_vs < 0) first_vs = i;
         if (de_a[i]) de_tot++;
         if (de_a[i] && i < 24) de_line0++;
         if (hs_a[i]) hs_tot++;
         if (hs_a[i] && i < 24) hs_line0++;
         if (hs_a[i] && !vs_a[i]) hs_in_vs++;
         if (!vs_a[i]) vs_low++;
         if (fs_a[i]) fs_cnt++;
         if (!de_a[i]) blank_or = blank_or | rgb_a[i];
      end
      for (int l = 0; l < 8; l++) begin
         line_has_de = 1'b0;
         for (int p = 0; p < 24; p++) line_has_de = line_has_de | de_a[l*24+p];
         if (line_has_de) act_lines++;
      end

      check_val("first_fs",        fs_a[0],       1'b1);
      check_val("first_de",        de_a[0],       1'b1);
      check_val("de_fall_idx",     first_de_fall, 16);
      check_val("de_line0_cnt",    de_line0,      16);
      check_val("hs_rise_idx",     first_hs,      18);
      check_val("hs_line0_cnt",    hs_line0,      3);
      check_val("hs_frame_cnt",    hs_tot,        24);
      check_val("de_frame_cnt",    de_tot,        64);
      check_val("active_lines",    act_lines,     4);
      check_val("vs_low_idx",      first_vs,      120);
      check_val("vs_low_cnt",      vs_low,        48);
      check_val("hs_during_vs",    hs_in_vs,      6);
      check_val("fs_per_frame",    fs_cnt,        1);
      check_val("blank_rgb",       blank_or,      24'h000000);
      for (int i = 0; i < 16; i++) check_val("bar_px", rgb_a[24+i], bars[i/2]);

      // Frame 1 starts with bars; a mid-frame switch to ramp must not show yet.
      tick();
      check_val("f1_fs",   vid.frame_start, 1'b1);
      check_val("f1_px0",  rgb_now(),       24'hFFFFFF);
      vid.pattern_sel = 2'd2;
      goto(192 + 28);
      check_val("f1_still_bars", rgb_now(), 24'h00FFFF);

      goto(384);
      check_val("f2_fs",   vid.frame_start, 1'b1);
      check_val("ramp_px0", rgb_now(),      24'h000000);
      for (int i = 1; i < 16; i++) begin
         tick();
         g = 8'(i);
         check_val("ramp_px", rgb_now(), {g, g, g});
      end
      goto(384 + 72 + 15);
      check_val("ramp_l3_last", rgb_now(), 24'h0F0F0F);

      vid.pattern_sel = 2'd3;
      goto(576);
      check_val("solid_px0",   rgb_now(), 24'h123456);
      goto(576 + 16);
      check_val("solid_blank", rgb_now(), 24'h000000);
      goto(576 + 30);
      check_val("solid_l1",    rgb_now(), 24'h123456);
      vid.solid_rgb = 24'hABCDEF;
      tick();
      check_val("solid_live",  rgb_now(), 24'hABCDEF);

      // Pattern 0 requested mid-frame, then reset lands with counters at h=10, v=2.
      vid.pattern_sel = 2'd0;
      goto(576 + 57);
      check_val("pre_rst_solid", rgb_now(), 24'hABCDEF);
      rst_n = 1'b0;
      tick();
      check_reset_outputs("mid_rst");
      rst_n = 1'b1;
      k = -1;
      tick();
      check_val("post_rst_fs",  vid.frame_start, 1'b1);
      check_val("post_rst_de",  vid.de,          1'b1);
      check_val("post_rst_px0", rgb_now(),       24'hFFFFFF);
      tick();
      tick();
      check_val("post_rst_px2", rgb_now(),       24'hFFFF00);
      check_val("post_rst_fs2", vid.frame_start, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
